serial_word_feeder: RTL and testbench

- Upstream stage of the serial two's-complement unit (`invert`).
- Accepts parallel words over a valid/ready handshake and shifts each word out LSB-first, one bit per clock, on `ser_bit`. `ser_bit` drives the complementer's serial input `i`.
- Generates `ser_clr`, which drives the complementer's clear input `r`, so that unit restarts its "first 1 seen" state at every word boundary.
- Provides `ser_valid` and `ser_last` framing for downstream collectors.

---
 rtl/serial_word_feeder.sv | 89 ++++++++
 tb/tb_serial_word_feeder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_feeder.sv
`default_nettype none
// ============================================================================
// Module      : serial_word_feeder
// Description : Accepts parallel words over valid/ready and shifts them out
//               LSB-first, framing each word with a one-cycle clear for the
//               downstream serial two's-complement unit.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_word_feeder #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_clr,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam logic [1:0]    c_IDLE     = 2'd0;
    localparam logic [1:0]    c_CLR      = 2'd1;
    localparam logic [1:0]    c_SHIFT    = 2'd2;
    localparam logic [CW-1:0] c_LAST_CNT = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic w_last;
    logic w_ready;
    logic w_hs;

    // Ready on the final bit as well as in IDLE so words can run back-to-back.
    always_comb begin
        w_last  = (state_q == c_SHIFT) && (cnt_q == c_LAST_CNT);
        w_ready = !r && ((state_q == c_IDLE) || w_last);
        w_hs    = in_valid && w_ready;
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q <= c_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (w_hs) state_d = c_CLR;
            c_CLR:   state_d = c_SHIFT;
            c_SHIFT: if (w_last) state_d = w_hs ? c_CLR : c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (w_hs) begin
            shreg_d = in_data;
            cnt_d   = '0;
        end else if (state_q == c_SHIFT) begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            cnt_d   = w_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        in_ready  = w_ready;
        ser_valid = (state_q == c_SHIFT);
        ser_bit   = (state_q == c_SHIFT) && shreg_q[0];
        ser_clr   = (state_q != c_SHIFT);
        ser_last  = w_last;
        busy      = (state_q != c_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_word_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_word_feeder
// Description : Directed self-checking bench for serial_word_feeder with a
//               behavioural serial two's-complement unit on its outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_word_feeder;

    logic       t_clk = 1'b0;
    logic       r;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       ser_bit;
    logic       ser_clr;
    logic       ser_valid;
    logic       ser_last;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    serial_word_feeder #(.WIDTH(8)) u_dut (
        .t_clk     (t_clk),
        .r         (r),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ser_bit   (ser_bit),
        .ser_clr   (ser_clr),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    always #5 t_clk = ~t_clk;

    // Serial two's complement: pass bits up to and including the first 1,
    // invert every bit after it.
    logic seen_q;
    logic comp_y;
    always @(posedge t_clk) begin
        if (ser_clr)      seen_q <= 1'b0;
        else if (ser_bit) seen_q <= 1'b1;
    end
    assign comp_y = ser_bit ^ seen_q;

    task automatic tick();
        @(posedge t_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic send_word(input logic [7:0] data, input logic [7:0] exp_comp, input string tag);
        logic [7:0] y;
        y = '0;
        in_valid = 1'b1;
        in_data  = data;
        check({tag, "_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        in_data  = ~data;
        check({tag, "_clr_clr"},   64'(ser_clr),   64'd1);
        check({tag, "_clr_valid"}, 64'(ser_valid), 64'd0);
        check({tag, "_clr_ready"}, 64'(in_ready),  64'd0);
        check({tag, "_clr_busy"},  64'(busy),      64'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("%s_valid%0d", tag, i), 64'(ser_valid), 64'd1);
            check($sformatf("%s_bit%0d", tag, i),   64'(ser_bit),   64'(data[i]));
            check($sformatf("%s_last%0d", tag, i),  64'(ser_last),  64'(i == 7));
            y[i] = comp_y;
        end
        check({tag, "_comp"}, 64'(y), 64'(exp_comp));
        tick();
        check({tag, "_idle_busy"},  64'(busy),     64'd0);
        check({tag, "_idle_clr"},   64'(ser_clr),  64'd1);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        logic [7:0] y0;
        logic [7:0] y1;
        int         b;

        r        = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        tick();
        check("rst_ready", 64'(in_ready),  64'd0);
        check("rst_busy",  64'(busy),      64'd0);
        check("rst_clr",   64'(ser_clr),   64'd1);
        check("rst_valid", 64'(ser_valid), 64'd0);
        check("rst_bit",   64'(ser_bit),   64'd0);
        check("rst_last",  64'(ser_last),  64'd0);
        in_valid = 1'b0;
        r        = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_ready%0d", i), 64'(in_ready),  64'd1);
            check($sformatf("idle_clr%0d", i),   64'(ser_clr),   64'd1);
            check($sformatf("idle_valid%0d", i), 64'(ser_valid), 64'd0);
            check($sformatf("idle_busy%0d", i),  64'(busy),      64'd0);
        end

        send_word(8'h06, 8'hFA, "w06");
        send_word(8'h00, 8'h00, "w00");
        send_word(8'hFF, 8'h01, "wFF");

        // Back-to-back 01 then 80 with in_valid held high.
        y0 = '0;
        y1 = '0;
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        in_data = 8'h80;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) tick();
            if (k == 9) in_valid = 1'b0;
            if (k == 0 || k == 9) begin
                check($sformatf("b2b_clr%0d", k),   64'(ser_clr),   64'd1);
                check($sformatf("b2b_valid%0d", k), 64'(ser_valid), 64'd0);
            end else begin
                w = (k < 9) ? 8'h01 : 8'h80;
                b = (k < 9) ? k - 1 : k - 10;
                check($sformatf("b2b_valid%0d", k), 64'(ser_valid), 64'd1);
                check($sformatf("b2b_bit%0d", k),   64'(ser_bit),   64'(w[b]));
                check($sformatf("b2b_last%0d", k),  64'(ser_last),  64'(b == 7));
                if (k < 9) y0[b] = comp_y;
                else       y1[b] = comp_y;
            end
            if (k == 8) check("b2b_ready_last", 64'(in_ready), 64'd1);
        end
        check("b2b_comp0", 64'(y0), 64'hFF);
        check("b2b_comp1", 64'(y1), 64'h80);
        tick();
        check("b2b_idle_busy", 64'(busy), 64'd0);

        // Reset during bit 3 of A5.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("rstmid_bit3",   64'(ser_bit),   64'd0);
        check("rstmid_valid3", 64'(ser_valid), 64'd1);
        r = 1'b1;
        check("rstmid_ready", 64'(in_ready), 64'd0);
        tick();
        check("rstmid_valid", 64'(ser_valid), 64'd0);
        check("rstmid_clr",   64'(ser_clr),   64'd1);
        check("rstmid_busy",  64'(busy),      64'd0);
        check("rstmid_last",  64'(ser_last),  64'd0);
        r = 1'b0;
        tick();
        check("rstmid_valid_after", 64'(ser_valid), 64'd0);
        send_word(8'h3C, 8'hC4, "w3C");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
